// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : ps2_pkg                                                      |
// | Brief   : Shared types and constants for the PS/2 receiver and the     |
// |           key-state tracker.                                           |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } ps2_state_e;

   localparam logic [7:0]  PS2_EXT        = 8'hE0;
   localparam logic [7:0]  PS2_BRK        = 8'hF0;
   localparam int unsigned PS2_FRAME_BITS = 11;

   // Frame layout after LSB-first shifting: [0]=start, [8:1]=data,
   // [9]=parity, [10]=stop. Data plus parity must carry odd parity.
   function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
      return (f[0] == 1'b0) && (^f[9:1] == 1'b1) && (f[10] == 1'b1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ps2_frame_rx                                                 |
// | Brief   : PS/2 frame receiver: pin synchronisers, sample tick, optional|
// |           clock glitch filter (PS2_GLITCH_FILTER_EN), 11-bit shift     |
// |           register, inactivity timeout and frame-check FSM.            |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 250,
   parameter int unsigned TIMEOUT_TICKS = 4000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       frame_err_o
);

   localparam int unsigned TICK_W = $clog2(CLK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
   localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);
   localparam int unsigned CNT_W = $clog2(PS2_FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PS2_FRAME_BITS - 1);

   logic                      clk_meta_q, clk_sync_q;
   logic                      dat_meta_q, dat_sync_q;
   logic [TICK_W-1:0]         tick_cnt_q;
   logic                      filt_q;
   logic                      w_filt_d;
   logic                      w_tick;
   logic                      w_fall;

   ps2_state_e                state_q, state_d;
   logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]          bits_q, bits_d;
   logic [TO_W-1:0]           to_q, to_d;

   assign w_tick = (tick_cnt_q == TICK_LAST);

   // Two-flop synchronisers for both pins; idle-high lines reset to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk_i;
         clk_sync_q <= clk_meta_q;
         dat_meta_q <= ps2_data_i;
         dat_sync_q <= dat_meta_q;
      end
   end

   // Free-running sample-tick divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else if (w_tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

`ifdef PS2_GLITCH_FILTER_EN
   // Previous two tick samples of the synchronised clock.
   logic [1:0] hist_q;

   // Keep a short history so the level only moves after 3 agreeing ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= 2'b11;
      end else if (w_tick) begin
         hist_q <= {hist_q[0], clk_sync_q};
      end
   end

   assign w_filt_d = ((clk_sync_q == hist_q[0]) && (clk_sync_q == hist_q[1]))
                   ? clk_sync_q : filt_q;
`else
   assign w_filt_d = clk_sync_q;
`endif

   // Filtered clock level as seen on the previous tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b1;
      end else if (w_tick) begin
         filt_q <= w_filt_d;
      end
   end

   assign w_fall = w_tick & filt_q & ~w_filt_d;
   assign byte_o = shift_q[8:1];

   // FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bits_q  <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bits_q  <= bits_d;
         to_q    <= to_d;
      end
   end

   // Next-state: collect 11 bits on falling edges, check in the cycle after.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bits_d       = bits_q;
      to_d         = to_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      case (state_q)
         IDLE: begin
            to_d = '0;
            if (w_fall) begin
               shift_d = {dat_sync_q, shift_q[PS2_FRAME_BITS-1:1]};
               bits_d  = CNT_W'(1);
               state_d = RECV;
            end
         end
         RECV: begin
            if (w_fall) begin
               shift_d = {dat_sync_q, shift_q[PS2_FRAME_BITS-1:1]};
               to_d    = '0;
               if (bits_q == LAST_BIT) begin
                  state_d = CHECK;
               end else begin
                  bits_d = bits_q + 1'b1;
               end
            end else if (to_q == TO_LIMIT) begin
               frame_err_o = 1'b1;
               state_d     = IDLE;
            end else if (w_tick) begin
               to_d = to_q + 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (ps2_frame_ok(shift_q)) begin
               byte_valid_o = 1'b1;
            end else begin
               frame_err_o = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ps2_key_tracker                                              |
// | Brief   : PS/2 keyboard receiver with E0/F0 prefix handling and a      |
// |           held/released table for NUM_KEYS programmable keys.          |
// |           Optional ps2_clk glitch filter: PS2_GLITCH_FILTER_EN.        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 250,
   parameter int unsigned TIMEOUT_TICKS = 4000,
   parameter int unsigned NUM_KEYS      = 4,
   parameter logic [NUM_KEYS*8-1:0] KEY_CODES = {8'h1D, 8'h1B, 8'h1C, 8'h23},
   parameter logic [NUM_KEYS-1:0]   KEY_EXT   = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic                code_valid,
   output logic [7:0]          code,
   output logic                code_ext,
   output logic                code_brk,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic                frame_err
);

   logic                w_byte_valid;
   logic [7:0]          w_byte;
   logic                w_frame_err;
   logic                w_code_hit;
   logic [NUM_KEYS-1:0] w_match;
   logic [NUM_KEYS-1:0] w_held_d;
   logic [NUM_KEYS-1:0] w_press_d;

   logic                ext_q, ext_d;
   logic                brk_q, brk_d;
   logic                code_valid_q;
   logic [7:0]          code_q;
   logic                code_ext_q;
   logic                code_brk_q;
   logic [NUM_KEYS-1:0] key_held_q;
   logic [NUM_KEYS-1:0] key_press_q;
   logic                frame_err_q;

   ps2_frame_rx #(
      .CLK_DIV       (CLK_DIV),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_valid_o (w_byte_valid),
      .byte_o       (w_byte),
      .frame_err_o  (w_frame_err)
   );

   // A good byte that is not a prefix completes a scan code.
   assign w_code_hit = w_byte_valid && (w_byte != PS2_EXT) && (w_byte != PS2_BRK);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      assign w_match[i]   = (w_byte == KEY_CODES[8*i +: 8]) && (ext_q == KEY_EXT[i]);
      assign w_held_d[i]  = (w_code_hit && w_match[i]) ? ~brk_q : key_held_q[i];
      assign w_press_d[i] = w_code_hit && w_match[i] && !brk_q && !key_held_q[i];
   end

   // Prefix flags: set by E0/F0, cleared by a completed code or a bad frame.
   always_comb begin
      ext_d = ext_q;
      brk_d = brk_q;
      if (w_frame_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (w_byte_valid) begin
         if (w_byte == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (w_byte == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   // Output, code and key-table registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         code_valid_q <= 1'b0;
         code_q       <= '0;
         code_ext_q   <= 1'b0;
         code_brk_q   <= 1'b0;
         key_held_q   <= '0;
         key_press_q  <= '0;
         frame_err_q  <= 1'b0;
      end else begin
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         code_valid_q <= w_code_hit;
         if (w_code_hit) begin
            code_q     <= w_byte;
            code_ext_q <= ext_q;
            code_brk_q <= brk_q;
         end
         key_held_q   <= w_held_d;
         key_press_q  <= w_press_d;
         frame_err_q  <= w_frame_err;
      end
   end

   assign code_valid = code_valid_q;
   assign code       = code_q;
   assign code_ext   = code_ext_q;
   assign code_brk   = code_brk_q;
   assign key_held   = key_held_q;
   assign key_press  = key_press_q;
   assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_ps2_key_tracker                                           |
// | Brief   : Self-checking bench: two trackers (plain and extended key 3) |
// |           share one PS/2 line and are compared against an event model. |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_ps2_key_tracker;

   localparam int unsigned TB_DIV = 4;
   localparam int unsigned TB_TO  = 40;
   localparam logic [31:0] CODES  = {8'h1D, 8'h1B, 8'h1C, 8'h23};

   typedef struct packed {
      logic       err;
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [3:0] held;
      logic [3:0] press;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic ps2_clk, ps2_data;

   logic       cv0, ce0, cb0, fe0, cv1, ce1, cb1, fe1;
   logic [7:0] cd0, cd1;
   logic [3:0] kh0, kp0, kh1, kp1;

   int vectors = 0;
   int miscompares = 0;

   ev_t        q0[$];
   ev_t        q1[$];
   bit         m_ext [2];
   bit         m_brk [2];
   logic [3:0] m_held [2];
   logic [3:0] last_held [2];
   logic [7:0] last_code [2];
   logic       last_ext [2];
   logic       last_brk [2];

   always #5 clk = ~clk;

   ps2_key_tracker #(
      .CLK_DIV (TB_DIV), .TIMEOUT_TICKS (TB_TO), .NUM_KEYS (4),
      .KEY_CODES (CODES), .KEY_EXT (4'b0000)
   ) dut (
      .clk (clk), .rst (rst), .ps2_clk (ps2_clk), .ps2_data (ps2_data),
      .code_valid (cv0), .code (cd0), .code_ext (ce0), .code_brk (cb0),
      .key_held (kh0), .key_press (kp0), .frame_err (fe0)
   );

   ps2_key_tracker #(
      .CLK_DIV (TB_DIV), .TIMEOUT_TICKS (TB_TO), .NUM_KEYS (4),
      .KEY_CODES (CODES), .KEY_EXT (4'b1000)
   ) dut_x (
      .clk (clk), .rst (rst), .ps2_clk (ps2_clk), .ps2_data (ps2_data),
      .code_valid (cv1), .code (cd1), .code_ext (ce1), .code_brk (cb1),
      .key_held (kh1), .key_press (kp1), .frame_err (fe1)
   );

   function automatic logic [3:0] kext(input int k);
      return (k == 1) ? 4'b1000 : 4'b0000;
   endfunction

   function automatic bit pop_ev(input int k, output ev_t e);
      e = '0;
      if (k == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1.pop_front();
      end
      return 1'b1;
   endfunction

   // Event-level model: what each received byte must cause at the outputs.
   task automatic model_byte(input logic [7:0] b, input bit good);
      for (int k = 0; k < 2; k++) begin
         ev_t e;
         logic [3:0] xm;
         e  = '0;
         xm = kext(k);
         if (!good) begin
            e.err = 1'b1;
            m_ext[k] = 1'b0;
            m_brk[k] = 1'b0;
         end else if (b == 8'hE0) begin
            m_ext[k] = 1'b1;
         end else if (b == 8'hF0) begin
            m_brk[k] = 1'b1;
         end else begin
            e.code = b;
            e.ext  = m_ext[k];
            e.brk  = m_brk[k];
            for (int i = 0; i < 4; i++) begin
               if (b == CODES[8*i +: 8] && m_ext[k] == xm[i]) begin
                  if (m_brk[k]) begin
                     m_held[k][i] = 1'b0;
                  end else begin
                     if (!m_held[k][i]) e.press[i] = 1'b1;
                     m_held[k][i] = 1'b1;
                  end
               end
            end
            e.held   = m_held[k];
            m_ext[k] = 1'b0;
            m_brk[k] = 1'b0;
         end
         if (e.err || (good && b != 8'hE0 && b != 8'hF0)) begin
            if (k == 0) q0.push_back(e); else q1.push_back(e);
         end
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ext[k] = 1'b0; m_brk[k] = 1'b0; m_held[k] = '0;
         last_held[k] = '0; last_code[k] = '0; last_ext[k] = 1'b0; last_brk[k] = 1'b0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic check_inst(input int k, input logic cv, input logic [7:0] cd,
                             input logic ce, input logic cb, input logic [3:0] kh,
                             input logic [3:0] kp, input logic fe);
      ev_t e;
      bit  got;
      vectors++;
      if (cv || fe) begin
         got = pop_ev(k, e);
         if (!got) begin
            miscompares++;
            $display("FAIL unexpected_event inst%0d: valid=%b err=%b code=%h, required none", k, cv, fe, cd);
         end else if (e.err) begin
            if (!(fe && !cv)) begin
               miscompares++;
               $display("FAIL frame_err inst%0d: valid=%b err=%b, required valid=0 err=1", k, cv, fe);
            end
         end else begin
            if ({cv, fe, cd, ce, cb, kh, kp} !== {1'b1, 1'b0, e.code, e.ext, e.brk, e.held, e.press}) begin
               miscompares++;
               $display("FAIL code_event inst%0d: v=%b e=%b code=%h ext=%b brk=%b held=%b press=%b, required v=1 e=0 code=%h ext=%b brk=%b held=%b press=%b",
                        k, cv, fe, cd, ce, cb, kh, kp, e.code, e.ext, e.brk, e.held, e.press);
            end
            last_held[k] = e.held; last_code[k] = e.code;
            last_ext[k]  = e.ext;  last_brk[k]  = e.brk;
         end
      end else if ({kh, kp, cd, ce, cb} !== {last_held[k], 4'b0000, last_code[k], last_ext[k], last_brk[k]}) begin
         miscompares++;
         $display("FAIL idle_state inst%0d: held=%b press=%b code=%h ext=%b brk=%b, required held=%b press=0000 code=%h ext=%b brk=%b",
                  k, kh, kp, cd, ce, cb, last_held[k], last_code[k], last_ext[k], last_brk[k]);
      end
   endtask

   // Per-cycle compare process, sampling on the falling clk edge.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst) begin
            check_inst(0, cv0, cd0, ce0, cb0, kh0, kp0, fe0);
            check_inst(1, cv1, cd1, ce1, cb1, kh1, kp1, fe1);
         end
      end
   endtask

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check_drained(input string name);
      vectors++;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL %s: %0d/%0d expected events never seen, required 0/0", name, q0.size(), q1.size());
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * TB_DIV) @(posedge clk);
      #2;
   endtask

   // ek: 0 good, 1 parity flipped, 2 start=1, 3 stop=0.
   task automatic send_frame(input logic [7:0] b, input int ek);
      logic [10:0] f;
      f[0]   = (ek == 2);
      f[8:1] = b;
      f[9]   = (~^b) ^ (ek == 1);
      f[10]  = (ek != 3);
      for (int i = 0; i < 11; i++) begin
         ps2_data = f[i];
         wait_ticks($urandom_range(4, 6));
         if (i == 10) model_byte(b, ek == 0);
         ps2_clk = 1'b0;
         wait_ticks($urandom_range(4, 6));
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_ticks(10);
      check_drained("frame_drain");
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         wait_ticks(5);
         ps2_clk = 1'b0;
         wait_ticks(5);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: bench did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] pick [7];
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      model_reset();
      fork
         monitor();
      join_none
      repeat (4) @(posedge clk);
      #2;
      check_lit("reset_outputs", {cv0, cd0, ce0, cb0, kh0, kp0, fe0}, 32'h0);
      rst = 1'b0;
      wait_ticks(4);

      // Single make of W
      send_frame(8'h1D, 0);
      check_lit("t1_code", cd0, 8'h1D);
      check_lit("t1_held", kh0, 4'b1000);

      // Typematic repeat then release
      send_frame(8'h1D, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h1D, 0);
      check_lit("t2_held", kh0, 4'b0000);
      check_lit("t2_brk", cb0, 1'b1);

      // Extended key on the second tracker
      send_frame(8'hE0, 0);
      send_frame(8'h1D, 0);
      check_lit("t3_ext", ce1, 1'b1);
      check_lit("t3_held_x", kh1, 4'b1000);
      check_lit("t3_held_plain", kh0, 4'b0000);
      send_frame(8'h1D, 0);
      check_lit("t3_held_x_again", kh1, 4'b1000);
      check_lit("t3_held_plain_again", kh0, 4'b1000);

      // Parity error then a good frame
      send_frame(8'h23, 1);
      check_lit("t4_after_err", kh0, 4'b1000);
      send_frame(8'h23, 0);
      check_lit("t4_held", kh0, 4'b1001);

      // Partial frame timeout then recovery
      send_bits(5);
      model_byte(8'h00, 1'b0);
      wait_ticks(TB_TO + 12);
      check_drained("t5_timeout");
      send_frame(8'h1C, 0);
      check_lit("t5_held", kh0, 4'b1011);

`ifdef PS2_GLITCH_FILTER_EN
      // Single-tick low pulse must not start a frame
      ps2_clk = 1'b0;
      repeat (TB_DIV) @(posedge clk);
      #2;
      ps2_clk = 1'b1;
      wait_ticks(8);
      send_frame(8'h1B, 0);
      check_lit("glitch_code", cd0, 8'h1B);
      send_frame(8'hF0, 0);
      send_frame(8'h1B, 0);
`endif

      // Build held=0101, then reset mid-frame
      send_frame(8'hF0, 0);
      send_frame(8'h1D, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h1C, 0);
      send_frame(8'h1B, 0);
      check_lit("t6_held_before", kh0, 4'b0101);
      send_bits(3);
      #1 rst = 1'b1;
      #1;
      check_lit("t6_held_reset", kh0, 4'b0000);
      check_lit("t6_held_reset_x", kh1, 4'b0000);
      model_reset();
      ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      wait_ticks(4);

      // Randomised traffic
      pick[0] = 8'h1D; pick[1] = 8'h1B; pick[2] = 8'h1C; pick[3] = 8'h23;
      pick[4] = 8'hE0; pick[5] = 8'hF0; pick[6] = 8'h00;
      for (int n = 0; n < 60; n++) begin
         int sel;
         logic [7:0] b;
         int ek;
         sel = $urandom_range(0, 6);
         b   = (sel == 6) ? 8'($urandom) : pick[sel];
         ek  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
         send_frame(b, ek);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
